// File: rtl/bcd_display_driver_pkg.sv
// Shared definitions for the two-digit BCD display driver: scan states,
// active-high segment glyphs ({g,f,e,d,c,b,a}) and a nibble validity helper.
package bcd_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_SHOW_U  = 2'd0,
    ST_BLANK_U = 2'd1,
    ST_SHOW_T  = 2'd2,
    ST_BLANK_T = 2'd3
  } state_t;

  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] GLYPH_OFF  = 7'h00;

  function automatic logic nibble_invalid(input logic [3:0] nibble);
    return (nibble > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Host-side bundle of the display driver: BCD load port plus the pin-level
// segment/anode outputs and status flags.
interface bcd_display_driver_if;

  logic [7:0] bcd_in;
  logic       load;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       frame_done;
  logic       err;

  modport master (
    output bcd_in, load,
    input  SEG, AN, frame_done, err
  );

  modport slave (
    input  bcd_in, load,
    output SEG, AN, frame_done, err
  );

endinterface

// File: rtl/bcd_display_driver_bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment glyph; 10-15 show a dash.
module bcd_to_7seg
  import bcd_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_DASH;
    case (nibble)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Two-digit multiplexed 7-segment driver with frame-synchronous value commit.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int SCAN_PERIOD    = 25000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  bcd_display_driver_if.slave bus
);

  localparam int SHOW_LEN = SCAN_PERIOD - BLANK_CYCLES;
  localparam int CNT_W    = $clog2(SCAN_PERIOD + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_LEN - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic             POL_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]       SEG_OFF_PIN = GLYPH_OFF ^ {7{POL_INV}};
  localparam logic [1:0]       AN_OFF_PIN  = 2'b00 ^ {2{POL_INV}};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       pending_reg;
  logic             pending_v_reg;
  logic [7:0]       shown_reg, shown_next;
  logic [6:0]       seg_reg, seg_next;
  logic [1:0]       an_reg, an_next;
  logic             frame_done_reg;
  logic             err_reg;
  logic             state_last;
  logic             commit;
  logic [6:0]       glyph [2];

  always_comb begin
    state_last = 1'b0;
    state_next = state_reg;
    case (state_reg)
      ST_SHOW_U: begin
        state_last = (cnt_reg == SHOW_LAST);
        if (state_last) state_next = ST_BLANK_U;
      end
      ST_BLANK_U: begin
        state_last = (cnt_reg == BLANK_LAST);
        if (state_last) state_next = ST_SHOW_T;
      end
      ST_SHOW_T: begin
        state_last = (cnt_reg == SHOW_LAST);
        if (state_last) state_next = ST_BLANK_T;
      end
      default: begin
        state_last = (cnt_reg == BLANK_LAST);
        if (state_last) state_next = ST_SHOW_U;
      end
    endcase
  end

  assign commit = state_last && (state_reg == ST_BLANK_T);

  // A load landing on the commit edge bypasses the pending register.
  always_comb begin
    shown_next = shown_reg;
    if (commit) begin
      if (bus.load)           shown_next = bus.bcd_in;
      else if (pending_v_reg) shown_next = pending_reg;
    end
  end

  // Decode from shown_next so the glyph tracks a commit on the same edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      bcd_to_7seg u_dec (
        .nibble (shown_next[gi*4 +: 4]),
        .glyph  (glyph[gi])
      );
    end
  endgenerate

  always_comb begin
    seg_next = GLYPH_OFF;
    an_next  = 2'b00;
    case (state_next)
      ST_SHOW_U: begin
        an_next  = 2'b01;
        seg_next = glyph[0];
      end
      ST_SHOW_T: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (shown_next[7:4] != 4'd0) begin
          an_next  = 2'b10;
          seg_next = glyph[1];
        end
`else
        an_next  = 2'b10;
        seg_next = glyph[1];
`endif
      end
      default: begin
        seg_next = GLYPH_OFF;
        an_next  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= ST_BLANK_T;
      cnt_reg        <= '0;
      pending_reg    <= 8'h00;
      pending_v_reg  <= 1'b0;
      shown_reg      <= 8'h00;
      seg_reg        <= SEG_OFF_PIN;
      an_reg         <= AN_OFF_PIN;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= state_last ? '0 : cnt_reg + CNT_W'(1);

      if (commit) begin
        pending_v_reg <= 1'b0;
      end else if (bus.load) begin
        pending_reg   <= bus.bcd_in;
        pending_v_reg <= 1'b1;
      end

      shown_reg      <= shown_next;
      seg_reg        <= seg_next ^ {7{POL_INV}};
      an_reg         <= an_next ^ {2{POL_INV}};
      frame_done_reg <= commit;
      err_reg        <= nibble_invalid(shown_next[7:4]) | nibble_invalid(shown_next[3:0]);
    end
  end

  assign bus.SEG        = seg_reg;
  assign bus.AN         = an_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed + randomized bench for bcd_display_driver against a frame-position model.
module tb_bcd_display_driver;

  localparam int S     = 8;
  localparam int B     = 2;
  localparam int SHOWN = S - B;
  localparam int FR    = 2 * S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         k = 0;
  logic [7:0] m_shown = 8'h00;
  logic [7:0] m_pend = 8'h00;
  logic       m_pend_v = 1'b0;
  logic [1:0] e_an;
  logic [6:0] e_seg;
  logic       e_fd;
  logic       e_err;

  logic [6:0] ref_glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_display_driver_if bus ();

  bcd_display_driver #(
    .SCAN_PERIOD    (S),
    .BLANK_CYCLES   (B),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .CLK_50M (clk),
    .RST_N   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic int phase_of(input int kk);
    return (kk < B) ? -1 : (kk - B) % FR;
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    return (n > 4'd9) ? 7'h40 : ref_glyph[n];
  endfunction

  task automatic check_all(input string tag, input logic [1:0] an_hi, input logic [6:0] seg_hi,
                           input logic fd, input logic er);
    checks++;
    assert (bus.AN === ~an_hi) else begin
      errors++;
      $error("FAIL %s_an k=%0d obs=%b exp=%b", tag, k, bus.AN, ~an_hi);
    end
    checks++;
    assert (bus.SEG === ~seg_hi) else begin
      errors++;
      $error("FAIL %s_seg k=%0d obs=%h exp=%h", tag, k, bus.SEG, ~seg_hi);
    end
    checks++;
    assert (bus.frame_done === fd) else begin
      errors++;
      $error("FAIL %s_fd k=%0d obs=%b exp=%b", tag, k, bus.frame_done, fd);
    end
    checks++;
    assert (bus.err === er) else begin
      errors++;
      $error("FAIL %s_err k=%0d obs=%b exp=%b", tag, k, bus.err, er);
    end
  endtask

  // One clock: drive inputs, advance the model by one edge, compare all outputs.
  task automatic step(input string tag, input logic ld, input logic [7:0] v);
    int ph;
    logic cm;
    bus.load   = ld;
    bus.bcd_in = v;
    @(posedge clk);
    k++;
    ph = phase_of(k);
    cm = (ph == 0);
    if (cm) begin
      if (ld) m_shown = v;
      else if (m_pend_v) m_shown = m_pend;
      m_pend_v = 1'b0;
    end else if (ld) begin
      m_pend   = v;
      m_pend_v = 1'b1;
    end
    e_an  = 2'b00;
    e_seg = 7'h00;
    if (ph >= 0 && ph < SHOWN) begin
      e_an  = 2'b01;
      e_seg = ref_seg(m_shown[3:0]);
    end else if (ph >= S && ph < S + SHOWN) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (m_shown[7:4] != 4'd0) begin
        e_an  = 2'b10;
        e_seg = ref_seg(m_shown[7:4]);
      end
`else
      e_an  = 2'b10;
      e_seg = ref_seg(m_shown[7:4]);
`endif
    end
    e_fd  = cm;
    e_err = (m_shown[7:4] > 4'd9) || (m_shown[3:0] > 4'd9);
    #1;
    $display("step %s k=%0d ph=%0d ld=%b v=%h AN=%b SEG=%h fd=%b err=%b",
             tag, k, ph, ld, v, bus.AN, bus.SEG, bus.frame_done, bus.err);
    check_all(tag, e_an, e_seg, e_fd, e_err);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00);
  endtask

  task automatic run_to_phase(input string tag, input int p);
    for (int i = 0; i < FR + B; i++) begin
      if (phase_of(k + 1) == p) break;
      step(tag, 1'b0, 8'h00);
    end
  endtask

  // Reset is asserted and released mid-cycle; outputs must go dark at once.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all({tag, "_now"}, 2'b00, 7'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_all({tag, "_hold"}, 2'b00, 7'h00, 1'b0, 1'b0);
    rst_n    = 1'b1;
    k        = 0;
    m_shown  = 8'h00;
    m_pend_v = 1'b0;
  endtask

  initial begin
    bus.load   = 1'b0;
    bus.bcd_in = 8'h00;
    #12;
    check_all("rst", 2'b00, 7'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;

    idle("idle", 2 * FR + B);

    run_to_phase("t2", 3);
    step("t2_load47", 1'b1, 8'h47);
    idle("t2", 2 * FR);

    run_to_phase("t3", 4);
    step("t3_load12", 1'b1, 8'h12);
    idle("t3", 5);
    step("t3_load35", 1'b1, 8'h35);
    idle("t3", 2 * FR);

    run_to_phase("t4", 0);
    step("t4_load99", 1'b1, 8'h99);
    idle("t4", 2 * FR);

    run_to_phase("t5", 5);
    step("t5_load3c", 1'b1, 8'h3C);
    idle("t5", FR + 4);
    step("t5_load21", 1'b1, 8'h21);
    idle("t5", 2 * FR);

    run_to_phase("t6", 2);
    step("t6_load05", 1'b1, 8'h05);
    idle("t6", FR);
    run_to_phase("t6", 1);
    step("t6_load05b", 1'b1, 8'h05);
    run_to_phase("t6", 10);
    do_reset("t6_rst");
    idle("t6_after", 2 * FR + B);

    step("t7_load05", 1'b1, 8'h05);
    idle("t7", 2 * FR);

    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(0, 5) == 0);
      step("rnd", ld, 8'($urandom_range(0, 255)));
      if (i == 200) begin
        run_to_phase("rnd", 9);
        do_reset("rnd_rst");
      end
    end
    idle("tail", FR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
